pc_fetch: RTL

//  Instruction-fetch stage. Owns the PC, fetches from instruction memory over a req/gnt/rvalid bus

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/pc_fetch.sv | 113 +++++++++++
 2 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM states, default NOP encoding and small address helpers.
package pc_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013; // addi x0,x0,0
    localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid with a single
// outstanding request, and presents {pc, inst, valid} to the IF/ID register.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fly_pc_q, fly_pc_d;
    logic [31:0]  slot_pc_q, slot_pc_d;
    logic [31:0]  slot_inst_q, slot_inst_d;
    logic         slot_vld_q, slot_vld_d;

    logic consume;
    logic slot_free;
    logic fire;

    assign consume   = slot_vld_q & ~stall_i;
    assign slot_free = ~slot_vld_q | consume;

    // A request only goes out when the slot can take its data, so the slot is
    // always empty by the time rvalid returns and nothing ever gets overwritten.
    assign imem_req_o  = (state_q == S_REQ) & slot_free;
    assign imem_addr_o = pc_q;
    assign fire        = imem_req_o & imem_gnt_i;

    assign if_pc_o    = slot_pc_q;
    assign if_inst_o  = slot_vld_q ? slot_inst_q : NOP_INST;
    assign if_valid_o = slot_vld_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fly_pc_d    = fly_pc_q;
        slot_pc_d   = slot_pc_q;
        slot_inst_d = slot_inst_q;
        slot_vld_d  = slot_vld_q;

        if (consume) slot_vld_d = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (fire) begin
                    fly_pc_d = pc_q;
                    pc_d     = pc_q + INST_BYTES;
                    state_d  = S_WAIT;
                end else if (!slot_free) begin
                    state_d = S_HOLD;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    slot_vld_d  = 1'b1;
                    slot_pc_d   = fly_pc_q;
                    slot_inst_d = imem_rdata_i;
                    state_d     = S_REQ;
                end
            end
            S_HOLD: if (consume) state_d = S_REQ;
            S_DROP: if (imem_rvalid_i) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over stall and every normal transition; a granted or
        // in-flight fetch that is still pending becomes stale (DROP).
        if (branch_i) begin
            pc_d       = align_word(branch_target_i);
            slot_vld_d = 1'b0;
            case (state_q)
                S_REQ:          state_d = fire ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_rvalid_i ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            fly_pc_q    <= RESET_PC;
            slot_pc_q   <= 32'h0;
            slot_inst_q <= NOP_INST;
            slot_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fly_pc_q    <= fly_pc_d;
            slot_pc_q   <= slot_pc_d;
            slot_inst_q <= slot_inst_d;
            slot_vld_q  <= slot_vld_d;
        end
    end

endmodule
